// File: rtl/lattice_init_pkg.sv
// Shared lattice packing definition: distribution width, direction count,
// wr_data slice positions per direction, and the init FSM state encoding.
package lattice_init_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int N_DIRS     = 9;

  // Direction order inside the packed word, c0 in the least significant slice
  localparam int DIR_C0  = 0;
  localparam int DIR_CN  = 1;
  localparam int DIR_CNE = 2;
  localparam int DIR_CE  = 3;
  localparam int DIR_CSE = 4;
  localparam int DIR_CS  = 5;
  localparam int DIR_CSW = 6;
  localparam int DIR_CW  = 7;
  localparam int DIR_CNW = 8;

  function automatic int slice_lsb(input int dir);
    return dir * DATA_WIDTH;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/lattice_init.sv
// Streams one identical packed distribution word to every lattice cell in
// row-major order, using a snapshot of the init values taken at start.
module lattice_init
  import lattice_init_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  localparam int N_CELLS = GRID_W * GRID_H,
  localparam int ADDR_W  = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_WIDTH-1:0]        init_c0,
  input  logic [DATA_WIDTH-1:0]        init_cn,
  input  logic [DATA_WIDTH-1:0]        init_cne,
  input  logic [DATA_WIDTH-1:0]        init_ce,
  input  logic [DATA_WIDTH-1:0]        init_cse,
  input  logic [DATA_WIDTH-1:0]        init_cs,
  input  logic [DATA_WIDTH-1:0]        init_csw,
  input  logic [DATA_WIDTH-1:0]        init_cw,
  input  logic [DATA_WIDTH-1:0]        init_cnw,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [N_DIRS*DATA_WIDTH-1:0] wr_data,
  output logic                         busy,
  output logic                         done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);

  state_e                         state, state_nxt;
  logic [ADDR_W-1:0]              cnt;
  logic [N_DIRS*DATA_WIDTH-1:0]   snap;
  logic                           accept;
  logic                           last;

  assign accept = wr_valid & wr_ready;
  assign last   = (cnt == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_WRITE;
      ST_WRITE: if (accept && last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_valid = (state == ST_WRITE);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
  end

  // Snapshot is only loaded from IDLE, so start pulses mid-run leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      snap <= '0;
    end else if (state == ST_IDLE && start) begin
      cnt <= '0;
      snap[slice_lsb(DIR_C0)  +: DATA_WIDTH] <= init_c0;
      snap[slice_lsb(DIR_CN)  +: DATA_WIDTH] <= init_cn;
      snap[slice_lsb(DIR_CNE) +: DATA_WIDTH] <= init_cne;
      snap[slice_lsb(DIR_CE)  +: DATA_WIDTH] <= init_ce;
      snap[slice_lsb(DIR_CSE) +: DATA_WIDTH] <= init_cse;
      snap[slice_lsb(DIR_CS)  +: DATA_WIDTH] <= init_cs;
      snap[slice_lsb(DIR_CSW) +: DATA_WIDTH] <= init_csw;
      snap[slice_lsb(DIR_CW)  +: DATA_WIDTH] <= init_cw;
      snap[slice_lsb(DIR_CNW) +: DATA_WIDTH] <= init_cnw;
    end else if (accept && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign wr_addr = cnt;
  assign wr_data = snap;

endmodule

// File: tb/tb_lattice_init.sv
// Bench for lattice_init: a 4x4 instance driven from a vector table and hand
// sequences with a beat scoreboard, plus a 1x1 instance for the single-cell case.
module tb_lattice_init;
  import lattice_init_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int WD = N_DIRS * DATA_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst, start4, start1, rdy4, rdy1;
  logic [N_DIRS-1:0][DW-1:0]  iv;

  logic          v4, busy4, done4;
  logic [3:0]    a4;
  logic [WD-1:0] d4;
  logic          v1, busy1, done1;
  logic [0:0]    a1;
  logic [WD-1:0] d1;

  lattice_init #(.GRID_W(4), .GRID_H(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .init_c0(iv[0]), .init_cn(iv[1]), .init_cne(iv[2]), .init_ce(iv[3]),
    .init_cse(iv[4]), .init_cs(iv[5]), .init_csw(iv[6]), .init_cw(iv[7]),
    .init_cnw(iv[8]),
    .wr_valid(v4), .wr_ready(rdy4), .wr_addr(a4), .wr_data(d4),
    .busy(busy4), .done(done4)
  );

  lattice_init #(.GRID_W(1), .GRID_H(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .init_c0(iv[0]), .init_cn(iv[1]), .init_cne(iv[2]), .init_ce(iv[3]),
    .init_cse(iv[4]), .init_cs(iv[5]), .init_csw(iv[6]), .init_cw(iv[7]),
    .init_cnw(iv[8]),
    .wr_valid(v1), .wr_ready(rdy1), .wr_addr(a1), .wr_data(d1),
    .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic [3:0]    addr;
    logic [WD-1:0] data;
  } beat_t;

  typedef struct {
    logic [WD-1:0] vals;
    int            mode;
  } vec_t;

  beat_t sbq[$];
  int    n_total = 0;
  int    n_pass  = 0;

  task automatic chk(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One 4x4 run; restart_beat/rst_beat < 0 disable those events
  task automatic run4(input logic [WD-1:0] vals, input int mode, input int restart_beat,
                      input bit start_in_done, input int rst_beat, input bit corrupt_cn,
                      input string tag);
    int accepted = 0, done_cnt = 0, done_cyc = -1, busy_cnt = 0, tail = 0;
    bit fin = 0, restarted = 0, prev_stall = 0, bad;
    logic [3:0] prev_a = '0;
    logic [WD-1:0] prev_d = '0;
    beat_t b;
    int exp_beats = (rst_beat >= 0) ? rst_beat : 16;

    @(negedge clk);
    iv = vals;
    start4 = 1'b1;
    for (int i = 0; i < 16; i++) sbq.push_back({4'(i), vals});
    @(negedge clk);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (corrupt_cn && cyc == 2) iv[1] = 16'hBEEF;
      start4 = 1'b0;
      if (restart_beat >= 0 && !restarted && v4 && accepted == restart_beat) begin
        start4 = 1'b1;
        restarted = 1'b1;
      end
      if (start_in_done && done4) start4 = 1'b1;
      rdy4 = ready_pat(mode, cyc);
      if (cyc == 0) begin
        chk({tag, "_first_valid"}, WD'(v4), WD'(1));
        chk({tag, "_first_addr"}, WD'(a4), WD'(0));
      end
      if (rst_beat >= 0 && v4 && accepted == rst_beat) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdy4 = 1'b1;
        chk({tag, "_rst_valid"}, WD'(v4), WD'(0));
        chk({tag, "_rst_busy"}, WD'(busy4), WD'(0));
        chk({tag, "_rst_data"}, d4, '0);
        chk({tag, "_rst_addr"}, WD'(a4), WD'(0));
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
          if (done4 || v4) bad = 1'b1;
          @(negedge clk);
        end
        chk({tag, "_rst_quiet"}, WD'(bad), WD'(0));
        sbq.delete();
        fin = 1'b1;
      end else begin
        if (v4 && prev_stall) begin
          chk({tag, "_stall_addr"}, WD'(a4), WD'(prev_a));
          chk({tag, "_stall_data"}, d4, prev_d);
        end
        if (busy4) busy_cnt++;
        if (v4 && rdy4) begin
          if (sbq.size() == 0) begin
            chk({tag, "_extra_beat"}, WD'(accepted + 1), WD'(exp_beats));
          end else begin
            b = sbq.pop_front();
            chk({tag, "_beat_addr"}, WD'(a4), WD'(b.addr));
            chk({tag, "_beat_data"}, d4, b.data);
          end
          accepted++;
        end
        if (done4) begin
          done_cnt++;
          if (done_cnt == 1) done_cyc = cyc;
          chk({tag, "_done_valid"}, WD'(v4), WD'(0));
        end
        prev_stall = v4 && !rdy4;
        prev_a = a4;
        prev_d = d4;
        if (done_cnt > 0) begin
          tail++;
          if (tail > 4) fin = 1'b1;
        end
        @(negedge clk);
      end
    end
    start4 = 1'b0;
    rdy4 = 1'b0;
    chk({tag, "_accepted"}, WD'(accepted), WD'(exp_beats));
    chk({tag, "_done_count"}, WD'(done_cnt), WD'((rst_beat >= 0) ? 0 : 1));
    chk({tag, "_sb_empty"}, WD'(sbq.size()), WD'(0));
    if (mode == 0 && rst_beat < 0) begin
      chk({tag, "_done_cycle"}, WD'(done_cyc), WD'(16));
      chk({tag, "_busy_cycles"}, WD'(busy_cnt), WD'(17));
    end
    sbq.delete();
  endtask

  localparam logic [WD-1:0] V_1TO9 = 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001;

  vec_t vecs[4];

  initial begin
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; rdy4 = 1'b0; rdy1 = 1'b0; iv = '0;
    vecs[0] = '{V_1TO9, 0};
    vecs[1] = '{V_1TO9, 1};
    vecs[2] = '{{N_DIRS{16'hFFFF}}, 2};
    vecs[3] = '{144'hA5A5_1234_0F0F_8000_7FFF_C3C3_0001_FEDC_5A5A, 0};

    repeat (3) @(negedge clk);
    chk("reset_valid", WD'(v4), WD'(0));
    chk("reset_busy", WD'(busy4), WD'(0));
    chk("reset_done", WD'(done4), WD'(0));
    chk("reset_addr", WD'(a4), WD'(0));
    chk("reset_data", d4, '0);
    rst = 1'b0;

    // rst and start together: reset wins
    @(negedge clk);
    iv = V_1TO9; rst = 1'b1; start4 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start4 = 1'b0;
    chk("rst_vs_start_busy", WD'(busy4), WD'(0));
    chk("rst_vs_start_data", d4, '0);

    for (int i = 0; i < 4; i++)
      run4(vecs[i].vals, vecs[i].mode, -1, 1'b0, -1, 1'b0, $sformatf("vec%0d", i));

    run4(V_1TO9, 0, -1, 1'b0, -1, 1'b1, "hold_cn");
    run4(V_1TO9, 0, 5, 1'b1, -1, 1'b0, "restart_ign");
    run4(V_1TO9, 0, -1, 1'b0, 7, 1'b0, "rst_abort");
    run4(vecs[3].vals, 0, -1, 1'b0, -1, 1'b0, "after_rst");

    // 1x1 lattice: one beat then done
    @(negedge clk);
    iv = vecs[3].vals; start1 = 1'b1; rdy1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("g1_valid", WD'(v1), WD'(1));
    chk("g1_addr", WD'(a1), WD'(0));
    chk("g1_data", d1, vecs[3].vals);
    @(negedge clk);
    chk("g1_done", WD'(done1), WD'(1));
    chk("g1_done_valid", WD'(v1), WD'(0));
    @(negedge clk);
    chk("g1_idle_busy", WD'(busy1), WD'(0));
    chk("g1_idle_done", WD'(done1), WD'(0));
    rdy1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
